// File: rtl/mux_arb_nx1_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux_arb_nx1_pkg
// Desc   : Shared mode encodings and sizing helper for the N-to-1 channel mux.
// Rev    : 1.0  initial release
// ============================================================================
package mux_arb_nx1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Elaboration-time ceil(log2(n)); returns 1 for n <= 2 so indices stay non-zero width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arb_nx1_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter_n
// Desc   : Combinational rotate-priority search: first request at or above ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter_n
    import mux_arb_nx1_pkg::*;
#(
    parameter int channels = 8,
    parameter int selw     = clog2(channels)
) (
    input  logic [channels-1:0] req,
    input  logic [selw-1:0]     ptr,
    output logic                gnt_valid,
    output logic [selw-1:0]     gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = channels - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= channels) begin
                idx = idx - channels;
            end
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = selw'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_arb_nx1.sv
`default_nettype none
// ============================================================================
// Module : mux_arb_nx1
// Desc   : Registered N-to-1 channel mux with fixed-select or round-robin grant.
// Rev    : 1.0  initial release
// ============================================================================
module mux_arb_nx1
    import mux_arb_nx1_pkg::*;
#(
    parameter int size     = 8,
    parameter int channels = 8,
    parameter int selw     = clog2(channels)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [selw-1:0]          sel,
    input  logic [size*channels-1:0] inputVal,
    input  logic [channels-1:0]      in_valid,
    output logic [channels-1:0]      in_ready,
    output logic [size-1:0]          y,
    output logic                     y_valid,
    output logic [selw-1:0]          y_chan,
    input  logic                     y_ready
);

    logic [size-1:0] y_q, y_d;
    logic            y_valid_q, y_valid_d;
    logic [selw-1:0] y_chan_q, y_chan_d;
    logic [selw-1:0] rr_ptr_q, rr_ptr_d;

    logic            w_load;
    logic            w_rr_valid;
    logic [selw-1:0] w_rr_idx;
    logic            w_fix_valid;
    logic            w_grant_valid;
    logic [selw-1:0] w_grant;
    logic            w_xfer;

    rr_arbiter_n #(
        .channels (channels),
        .selw     (selw)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    // Out-of-range sel values never match a channel index, so they never grant.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (sel == selw'(i) && in_valid[i]) begin
                w_fix_valid = 1'b1;
            end
        end
    end

    assign w_load        = ~y_valid_q | y_ready;
    assign w_grant       = (mode == MODE_RR) ? w_rr_idx   : sel;
    assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
    assign w_xfer        = ~rst & w_load & w_grant_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < channels; i++) begin
            if (w_xfer && w_grant == selw'(i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_chan_d  = y_chan_q;
        rr_ptr_d  = rr_ptr_q;
        if (w_xfer) begin
            y_d       = inputVal[int'(w_grant)*size +: size];
            y_chan_d  = w_grant;
            y_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = (w_grant == selw'(channels - 1)) ? '0 : w_grant + 1'b1;
            end
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_chan_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_chan_q  <= y_chan_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_chan  = y_chan_q;

    a_ready_onehot0 : assert property (@(posedge clk) $onehot0(in_ready));
    a_ready_has_valid : assert property (@(posedge clk) (in_ready & ~in_valid) == '0);
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (y_valid_q && !y_ready) |=> ($stable(y_q) && $stable(y_chan_q) && y_valid_q));

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_nx1.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_arb_nx1
// Desc   : Randomized bench for mux_arb_nx1 against a behavioural reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux_arb_nx1;

    localparam int SIZE = 8;
    localparam int CH   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [2:0]      sel;
    logic [SIZE*CH-1:0] inputVal;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [SIZE-1:0] y;
    logic            y_valid;
    logic [2:0]      y_chan;
    logic            y_ready;

    logic [95:0]     iv3;
    logic [2:0]      inv3;
    logic [2:0]      rdy3;
    logic [31:0]     y3;
    logic            yv3;
    logic [1:0]      ch3;

    always #5 clk = ~clk;

    mux_arb_nx1 #(.size(SIZE), .channels(CH)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .inputVal(inputVal),
        .in_valid(in_valid), .in_ready(in_ready), .y(y), .y_valid(y_valid),
        .y_chan(y_chan), .y_ready(y_ready)
    );

    mux_arb_nx1 #(.size(32), .channels(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(1'b0), .sel(2'd3), .inputVal(iv3),
        .in_valid(inv3), .in_ready(rdy3), .y(y3), .y_valid(yv3),
        .y_chan(ch3), .y_ready(1'b1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: the word the consumer currently sees, and the next round-robin start.
    int          m_ptr   = 0;
    logic [7:0]  m_y     = '0;
    logic        m_v     = 1'b0;
    int          m_chan  = 0;
    bit          m_known = 1'b0;
    logic [CH-1:0] pend  = '0;

    function automatic int pick(input logic md, input int s, input logic [CH-1:0] v, input int ptr);
        if (md == 1'b0) begin
            return (s < CH && v[s]) ? s : -1;
        end
        for (int k = 0; k < CH; k++) begin
            if (v[(ptr + k) % CH]) return (ptr + k) % CH;
        end
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic md, input int s,
                         input logic [CH-1:0] v, input logic yr);
        int g;
        logic [CH-1:0] exp_rdy;
        @(negedge clk);
        rst = r; mode = md; sel = 3'(s); in_valid = v; y_ready = yr;
        for (int i = 0; i < CH; i++) begin
            if (!pend[i]) inputVal[i*SIZE +: SIZE] = 8'($urandom);
        end
        iv3  = {$urandom, $urandom, $urandom};
        inv3 = 3'($urandom);
        #1;
        g = (r || !(!m_v || yr)) ? -1 : pick(md, s, v, m_ptr);
        exp_rdy = (g >= 0) ? CH'(1) << g : '0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("sweep_in_ready", 64'(rdy3), 64'd0);
        if (m_known) begin
            check("y_valid", 64'(y_valid), 64'(m_v));
            check("y_chan", 64'(y_chan), 64'(m_chan));
            check("y", 64'(y), 64'(m_y));
            check("sweep_y_valid", 64'(yv3), 64'd0);
        end
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_y = '0; m_v = 1'b0; m_chan = 0; m_known = 1'b1;
            pend = '0;
        end else begin
            for (int i = 0; i < CH; i++) pend[i] = v[i] && (g != i);
            if (g >= 0) begin
                m_y = inputVal[g*SIZE +: SIZE];
                m_chan = g;
                m_v = 1'b1;
                if (md) m_ptr = (g + 1) % CH;
            end else if (m_v && yr) begin
                m_v = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b1; sel = '0; inputVal = '0; in_valid = '0; y_ready = 1'b0;
        iv3 = '0; inv3 = '0;

        repeat (2) cycle(1'b1, 1'b1, 0, 8'hFF, 1'b1);
        cycle(1'b0, 1'b1, 0, 8'hFF, 1'b1);

        repeat (3) cycle(1'b0, 1'b0, 5, 8'hFF, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 3, 8'hF7, 1'b1);

        repeat (17) cycle(1'b0, 1'b1, 0, 8'hFF, 1'b1);

        cycle(1'b0, 1'b1, 0, 8'h20, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 0, 8'h05, 1'b1);

        cycle(1'b0, 1'b1, 0, 8'hFF, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 0, CH'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 0, 8'h10, 1'b1);
        cycle(1'b0, 1'b1, 0, 8'h00, 1'b1);

        cycle(1'b0, 1'b1, 0, 8'hFF, 1'b0);
        cycle(1'b0, 1'b1, 0, 8'hFF, 1'b0);
        cycle(1'b1, 1'b1, 0, 8'hFF, 1'b0);
        cycle(1'b0, 1'b1, 0, 8'h00, 1'b0);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 7)),
                  CH'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
